// File: rtl/trace_event_monitor.sv
// Trace event monitor: captures l.nop K events from retiring cores into a shared show-ahead FIFO.
// Optional core backpressure output is compiled in with TRACE_EVENT_MONITOR_STALL_EN.

module trace_event_lane (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [31:0] insn,
    input  logic [31:0] pc,
    input  logic        wben,
    input  logic [4:0]  wbreg,
    input  logic [31:0] wbdata,
    input  logic        grant,
    output logic        slot_vld,
    output logic [15:0] slot_code,
    output logic [31:0] slot_data,
    output logic [31:0] slot_pc,
    output logic        term,
    output logic        drop
);
    logic [31:0] r3;
    logic        detect;

    assign detect = enable && (insn[31:16] == 16'h1500) && !term;
    // A full slot only accepts a new event when it drains in the same cycle.
    assign drop   = detect && slot_vld && !grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r3        <= '0;
            term      <= 1'b0;
            slot_vld  <= 1'b0;
            slot_code <= '0;
            slot_data <= '0;
            slot_pc   <= '0;
        end else begin
            if (enable && wben && (wbreg == 5'd3))
                r3 <= wbdata;
            if (detect && (insn[15:0] == 16'd1))
                term <= 1'b1;
            if (detect && !drop) begin
                slot_vld  <= 1'b1;
                slot_code <= insn[15:0];
                slot_data <= r3;
                slot_pc   <= pc;
            end else if (grant) begin
                slot_vld <= 1'b0;
            end
        end
    end
endmodule

module trace_event_monitor #(
    parameter int NUMCORES   = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUMCORES-1:0]    trace_enable,
    input  logic [32*NUMCORES-1:0] trace_insn,
    input  logic [32*NUMCORES-1:0] trace_pc,
    input  logic [NUMCORES-1:0]    trace_wben,
    input  logic [5*NUMCORES-1:0]  trace_wbreg,
    input  logic [32*NUMCORES-1:0] trace_wbdata,
    output logic                   ev_valid,
    input  logic                   ev_ready,
    output logic [3:0]             ev_core,
    output logic [15:0]            ev_code,
    output logic [31:0]            ev_data,
    output logic [31:0]            ev_pc,
    output logic [NUMCORES-1:0]    terminated,
    output logic                   all_terminated,
    output logic [7:0]             drop_count,
    output logic                   cpu_stall
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [3:0]  core;
        logic [15:0] code;
        logic [31:0] data;
        logic [31:0] pc;
    } ev_t;

    logic [NUMCORES-1:0]        slot_vld, grant_vec, drop;
    logic [NUMCORES-1:0][15:0]  slot_code;
    logic [NUMCORES-1:0][31:0]  slot_data, slot_pc;

    for (genvar g = 0; g < NUMCORES; g++) begin : g_lane
        trace_event_lane u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .enable    (trace_enable[g]),
            .insn      (trace_insn[32*g +: 32]),
            .pc        (trace_pc[32*g +: 32]),
            .wben      (trace_wben[g]),
            .wbreg     (trace_wbreg[5*g +: 5]),
            .wbdata    (trace_wbdata[32*g +: 32]),
            .grant     (grant_vec[g]),
            .slot_vld  (slot_vld[g]),
            .slot_code (slot_code[g]),
            .slot_data (slot_data[g]),
            .slot_pc   (slot_pc[g]),
            .term      (terminated[g]),
            .drop      (drop[g])
        );
    end

    ev_t         mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          fifo_full, push, pop;
    logic [3:0]    rr_ptr, grant_idx;
    ev_t           push_ev, head;
    int            c;

    assign fifo_full = (count == (AW+1)'(FIFO_DEPTH));
    assign ev_valid  = (count != '0);
    assign pop       = ev_valid && ev_ready;
    assign head      = mem[rd_ptr];
    assign ev_core   = head.core;
    assign ev_code   = head.code;
    assign ev_data   = head.data;
    assign ev_pc     = head.pc;
    assign all_terminated = &terminated;

    // Round-robin search beginning at the core after the previous grant.
    always_comb begin
        grant_vec = '0;
        push      = 1'b0;
        grant_idx = '0;
        push_ev   = '0;
        c         = 0;
        if (!fifo_full) begin
            for (int i = 0; i < NUMCORES; i++) begin
                c = int'(rr_ptr) + i;
                if (c >= NUMCORES) c = c - NUMCORES;
                if (!push && slot_vld[c]) begin
                    push         = 1'b1;
                    grant_idx    = 4'(c);
                    grant_vec[c] = 1'b1;
                    push_ev      = '{core: 4'(c), code: slot_code[c], data: slot_data[c], pc: slot_pc[c]};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_ev;
    end

    logic [4:0] drop_sum;
    logic [8:0] drop_tot;

    always_comb begin
        drop_sum = '0;
        for (int i = 0; i < NUMCORES; i++)
            drop_sum = drop_sum + 5'(drop[i]);
        drop_tot = 9'(drop_count) + 9'(drop_sum);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rr_ptr     <= '0;
            drop_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= (grant_idx == 4'(NUMCORES-1)) ? 4'd0 : grant_idx + 4'd1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            drop_count <= (drop_tot > 9'd255) ? 8'hFF : drop_tot[7:0];
        end
    end

`ifdef TRACE_EVENT_MONITOR_STALL_EN
    logic        stall_q;
    logic [AW:0] free_cnt;

    assign free_cnt = (AW+1)'(FIFO_DEPTH) - count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_q <= 1'b0;
        else
            stall_q <= (|slot_vld) || (int'(free_cnt) < NUMCORES);
    end

    assign cpu_stall = stall_q;
`else
    assign cpu_stall = 1'b0;
`endif
endmodule

// File: tb/tb_trace_event_monitor.sv
// Scoreboard bench for trace_event_monitor: stimulus pushes expected events, a negedge monitor pops and compares.

module tb_trace_event_monitor;
    localparam int NC = 4;
    localparam int FD = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NC-1:0]   trace_enable, trace_wben, terminated;
    logic [32*NC-1:0] trace_insn, trace_pc, trace_wbdata;
    logic [5*NC-1:0] trace_wbreg;
    logic            ev_valid, ev_ready, all_terminated, cpu_stall;
    logic [3:0]      ev_core;
    logic [15:0]     ev_code;
    logic [31:0]     ev_data, ev_pc;
    logic [7:0]      drop_count;

    always #5 clk = ~clk;

    trace_event_monitor #(.NUMCORES(NC), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst_n(rst_n),
        .trace_enable(trace_enable), .trace_insn(trace_insn), .trace_pc(trace_pc),
        .trace_wben(trace_wben), .trace_wbreg(trace_wbreg), .trace_wbdata(trace_wbdata),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_core(ev_core), .ev_code(ev_code),
        .ev_data(ev_data), .ev_pc(ev_pc), .terminated(terminated),
        .all_terminated(all_terminated), .drop_count(drop_count), .cpu_stall(cpu_stall)
    );

    typedef struct {
        logic [31:0] core;
        logic [31:0] code;
        logic [31:0] data;
        logic [31:0] pc;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   passed = 0;
    int   total  = 0;
    int   cyc_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push_exp(input int core, input int code, input logic [31:0] data,
                            input logic [31:0] pc, input int cyc);
        exp_t e;
        e.core = 32'(core); e.code = 32'(code); e.data = data; e.pc = pc; e.cyc = cyc;
        sbq.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        cyc_cnt++;
    end

    // Monitor: pops on every accepted head event; also checks head stability while stalled.
    initial begin
        logic        prev_hold;
        logic [31:0] p_pc, p_data;
        logic [15:0] p_code;
        logic [3:0]  p_core;
        exp_t        e;
        prev_hold = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold && ev_valid) begin
                    chk("hold_pc", ev_pc, p_pc);
                    chk("hold_data", ev_data, p_data);
                    chk("hold_code_core", {ev_core, ev_code}, {p_core, p_code});
                end
                if (ev_valid && ev_ready) begin
                    if (sbq.size() == 0) begin
                        total++;
                        $display("FAIL unexpected_event: got core %0d code %0d pc 0x%0h, expected no event",
                                 ev_core, ev_code, ev_pc);
                    end else begin
                        e = sbq.pop_front();
                        chk("ev_core", ev_core, e.core);
                        chk("ev_code", ev_code, e.code);
                        chk("ev_data", ev_data, e.data);
                        chk("ev_pc", ev_pc, e.pc);
                        if (e.cyc >= 0) chk("ev_cycle", cyc_cnt, e.cyc);
                    end
                end
                prev_hold = ev_valid && !ev_ready;
                p_pc = ev_pc; p_data = ev_data; p_code = ev_code; p_core = ev_core;
            end
        end
    end

    task automatic idle_inputs();
        trace_enable = '0; trace_wben = '0; trace_insn = '0;
        trace_pc = '0; trace_wbreg = '0; trace_wbdata = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic nop(input int c, input int k, input logic [31:0] pc);
        trace_enable[c] = 1'b1;
        trace_insn[32*c +: 32] = {16'h1500, 16'(k)};
        trace_pc[32*c +: 32] = pc;
    endtask

    task automatic wr3(input int c, input logic [31:0] d);
        trace_enable[c] = 1'b1;
        trace_wben[c] = 1'b1;
        trace_wbreg[5*c +: 5] = 5'd3;
        trace_wbdata[32*c +: 32] = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sbq.delete();
        idle_inputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (sbq.size() == 0) break;
            step();
        end
        chk("drain_pending", sbq.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst_n = 1'b0;
        ev_ready = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ev_valid", ev_valid, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_term", terminated, 0);
        chk("rst_all_term", all_terminated, 0);
        chk("rst_stall", cpu_stall, 0);
        rst_n = 1'b1;
        step();

        // Single event latency and r3 capture
        ev_ready = 1'b1;
        wr3(0, 32'h2A); step();
        t = cyc_cnt; nop(0, 2, 32'h100); push_exp(0, 2, 32'h2A, 32'h100, t + 2); step();
        repeat (3) step();
        // Event data is the r3 value before a same-cycle writeback
        wr3(1, 32'h11); step();
        t = cyc_cnt; nop(1, 3, 32'h104); wr3(1, 32'h77); push_exp(1, 3, 32'h11, 32'h104, t + 2); step();
        t = cyc_cnt; nop(1, 3, 32'h108); push_exp(1, 3, 32'h77, 32'h108, t + 2); step();
        drain(10);

        // Simultaneous bursts: round-robin 0..3, then wrap to 0
        do_reset();
        ev_ready = 1'b1;
        t = cyc_cnt;
        for (int c = 0; c < NC; c++) begin
            nop(c, 4, 32'h200 + 32'(4*c));
            push_exp(c, 4, 32'h0, 32'h200 + 32'(4*c), t + 2 + c);
        end
        repeat (5) step();
        t = cyc_cnt;
        for (int c = 0; c < NC; c++) begin
            nop(c, 4, 32'h210 + 32'(4*c));
            push_exp(c, 4, 32'h0, 32'h210 + 32'(4*c), t + 2 + c);
        end
        step();
        drain(12);

        // Overflow: 8 in FIFO, 1 pending, 3 dropped, then saturation
        do_reset();
        ev_ready = 1'b0;
        for (int k = 0; k < 12; k++) begin
            nop(0, 16 + k, 32'h300 + 32'(4*k));
            if (k <= 8) push_exp(0, 16 + k, 32'h0, 32'h300 + 32'(4*k), -1);
            step();
        end
        chk("drop_3", drop_count, 3);
        chk("full_ev_valid", ev_valid, 1);
`ifndef TRACE_EVENT_MONITOR_STALL_EN
        chk("no_stall_build", cpu_stall, 0);
`endif
        for (int k = 0; k < 260; k++) begin
            nop(0, 40, 32'h3F0);
            step();
        end
        chk("drop_sat", drop_count, 8'hFF);
        ev_ready = 1'b1;
        drain(40);

        // Exit events and termination
        do_reset();
        ev_ready = 1'b1;
        wr3(1, 32'h5); step();
        t = cyc_cnt;
        nop(0, 1, 32'h400); nop(1, 1, 32'h404);
        push_exp(0, 1, 32'h0, 32'h400, t + 2);
        push_exp(1, 1, 32'h5, 32'h404, t + 3);
        step();
        chk("term_2", terminated, 4'b0011);
        chk("all_term_partial", all_terminated, 0);
        nop(2, 1, 32'h408); nop(3, 1, 32'h40C);
        push_exp(2, 1, 32'h0, 32'h408, -1);
        push_exp(3, 1, 32'h0, 32'h40C, -1);
        step();
        chk("term_all", terminated, 4'hF);
        chk("all_term", all_terminated, 1);
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < NC; c++) nop(c, 7, 32'h480);
            step();
        end
        drain(20);
        repeat (5) step();
        chk("term_sticky", terminated, 4'hF);

        // Reset with queued events
        do_reset();
        ev_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            nop(0, 5, 32'h500 + 32'(4*k));
            if (k == 0) nop(1, 1, 32'h580);
            step();
        end
        repeat (3) step();
        chk("pre_rst_valid", ev_valid, 1);
        chk("pre_rst_term", terminated, 4'b0010);
        #2;
        rst_n = 1'b0;
        sbq.delete();
        #1;
        chk("rst_async_valid", ev_valid, 0);
        chk("rst_async_term", all_terminated, 0);
        chk("rst_async_stall", cpu_stall, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ev_ready = 1'b1;
        repeat (3) step();
        chk("post_rst_valid", ev_valid, 0);
        chk("post_rst_drop", drop_count, 0);
        chk("post_rst_term", terminated, 0);

        chk("sb_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
